rom_stream_reader: RTL

Sequencing reader for the combinational `rom` block. It drives the ROM address, captures each word into a register and emits a run of consecutive words as a valid/ready stream. Downstream consumers (bias/weight loaders of the classifier datapath) receive the stream. Each run is started by a single `start` pulse that carries a base address and a length, and the block signals completion with a one-cycle `done` pulse.

---
 rtl/rom_reader_pkg.sv | 9 +
 rtl/rom_stream_reader.sv | 104 ++++++++++
 2 files changed

// File: rtl/rom_reader_pkg.sv
// Shared types for the ROM stream reader: controller state encoding.
package rom_reader_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

endpackage

// File: rtl/rom_stream_reader.sv
// Streams a run of consecutive words from a combinational ROM as a valid/ready stream.
// First beat valid one cycle after start; m_valid/m_data hold under backpressure, one beat per cycle otherwise.
module rom_stream_reader
  import rom_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready
);

  // One bit wider than length so base+length can never wrap, even for the largest length.
  localparam int CW = ADDR_WIDTH + 2;

  state_t                state_q, state_n;
  logic [ADDR_WIDTH-1:0] rd_addr, rd_addr_n;
  logic [ADDR_WIDTH:0]   remaining, remaining_n;
  logic [DATA_WIDTH-1:0] data_n;
  logic                  valid_n, done_n, err_n;
  logic [CW-1:0]         req_end;
  logic                  accept;

  assign req_end  = CW'(base_addr) + CW'(length);
  assign accept   = m_valid && m_ready;
  assign rom_addr = (state_q == STREAM) ? rd_addr : base_addr;
  assign busy     = (state_q == STREAM);
  assign m_last   = m_valid && (remaining == '0);

  always_comb begin
    state_n     = state_q;
    rd_addr_n   = rd_addr;
    remaining_n = remaining;
    data_n      = m_data;
    valid_n     = m_valid;
    done_n      = 1'b0;
    err_n       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (req_end > CW'(DATA_DEPTH)) begin
            err_n = 1'b1;
          end else if (length == '0) begin
            done_n = 1'b1;
          end else begin
            data_n      = rom_data;
            valid_n     = 1'b1;
            rd_addr_n   = base_addr + ADDR_WIDTH'(1);
            remaining_n = length - (ADDR_WIDTH + 1)'(1);
            state_n     = STREAM;
          end
        end
      end
      STREAM: begin
        if (accept) begin
          if (remaining == '0) begin
            valid_n = 1'b0;
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            data_n      = rom_data;
            rd_addr_n   = rd_addr + ADDR_WIDTH'(1);
            remaining_n = remaining - (ADDR_WIDTH + 1)'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rd_addr   <= '0;
      remaining <= '0;
      m_data    <= '0;
      m_valid   <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_n;
      rd_addr   <= rd_addr_n;
      remaining <= remaining_n;
      m_data    <= data_n;
      m_valid   <= valid_n;
      done      <= done_n;
      err       <= err_n;
    end
  end

endmodule
